// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM: states, opcodes,
// ALU operand/operation selects, fault codes and the control-word bundle.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'b00,
    SRC_A_RS1    = 2'b01,
    SRC_A_OLD_PC = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_FOUR = 2'b01,
    SRC_B_IMM  = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    FAULT_NONE        = 2'b00,
    FAULT_ILLEGAL_OP  = 2'b01,
    FAULT_MEM_TIMEOUT = 2'b10
  } fault_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_src;
  } ctrl_t;

  // Opcodes that proceed from DECODE into EXEC.
  function automatic logic is_exec_opcode(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive mem_ready-low cycles of one memory access and flags the
// cycle that would be the LIMIT-th wait.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic limit_reached
);

  logic [7:0] count_r;

  // Wait counter; clear wins over count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (count) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign limit_reached = (count_r == 8'(LIMIT - 32'd1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// sticky fault register and a bounded wait on every memory access.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_src,
  output logic [1:0] fault,
  output logic [2:0] state
);

  state_t     state_r;
  state_t     next_state_s;
  logic [6:0] op_r;
  logic [1:0] fault_r;
  logic [1:0] next_fault_s;
  logic       waiting_s;
  logic       limit_s;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_out_s;

  assign waiting_s = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ready;

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (next_state_s != state_r),
    .count         (waiting_s),
    .limit_reached (limit_s)
  );

  // State, sticky fault and opcode latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
      fault_r <= FAULT_NONE;
      op_r    <= 7'd0;
    end else begin
      state_r <= next_state_s;
      fault_r <= next_fault_s;
      op_r    <= (state_r == ST_DECODE) ? opcode : op_r;
    end
  end

  // Next-state and fault logic; a ready in the limit cycle completes the access.
  always_comb begin
    next_state_s = state_r;
    next_fault_s = fault_r;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) begin
          next_state_s = ST_DECODE;
        end else if (limit_s) begin
          next_state_s = ST_HALT;
          next_fault_s = FAULT_MEM_TIMEOUT;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_exec_opcode(opcode)) begin
          next_state_s = ST_EXEC;
        end else if (opcode == OP_NOP) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_HALT;
          next_fault_s = FAULT_ILLEGAL_OP;
        end
      end
      ST_EXEC: begin
        case (op_r)
          OP_LOAD, OP_STORE: next_state_s = ST_MEM;
          OP_RTYPE, OP_ITYPE: next_state_s = ST_WB;
          default: next_state_s = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          next_state_s = (op_r == OP_LOAD) ? ST_WB : ST_FETCH;
        end else if (limit_s) begin
          next_state_s = ST_HALT;
          next_fault_s = FAULT_MEM_TIMEOUT;
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WB:   next_state_s = ST_FETCH;
      ST_HALT: next_state_s = ST_HALT;
      default: next_state_s = ST_HALT;
    endcase
  end

  // Control word for the current state; EXEC/MEM/WB decode from the latched opcode.
  always_comb begin
    ctrl_s = '0;
    case (state_r)
      ST_FETCH: begin
        ctrl_s.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl_s.ir_write  = 1'b1;
          ctrl_s.pc_write  = 1'b1;
          ctrl_s.alu_src_a = SRC_A_PC;
          ctrl_s.alu_src_b = SRC_B_FOUR;
          ctrl_s.alu_op    = ALU_ADD;
        end else begin
          ctrl_s.ir_write = 1'b0;
        end
      end
      ST_DECODE: begin
        ctrl_s.alu_src_a = SRC_A_OLD_PC;
        ctrl_s.alu_src_b = SRC_B_IMM;
        ctrl_s.alu_op    = ALU_ADD;
      end
      ST_EXEC: begin
        case (op_r)
          OP_RTYPE: begin
            ctrl_s.alu_src_a = SRC_A_RS1;
            ctrl_s.alu_src_b = SRC_B_RS2;
            ctrl_s.alu_op    = ALU_FUNCT;
          end
          OP_ITYPE: begin
            ctrl_s.alu_src_a = SRC_A_RS1;
            ctrl_s.alu_src_b = SRC_B_IMM;
            ctrl_s.alu_op    = ALU_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            ctrl_s.alu_src_a = SRC_A_RS1;
            ctrl_s.alu_src_b = SRC_B_IMM;
            ctrl_s.alu_op    = ALU_ADD;
          end
          OP_BRANCH: begin
            ctrl_s.alu_src_a = SRC_A_RS1;
            ctrl_s.alu_src_b = SRC_B_RS2;
            ctrl_s.alu_op    = ALU_SUB;
            ctrl_s.pc_src    = 1'b1;
            ctrl_s.pc_write  = zero;
          end
          default: ctrl_s = '0;
        endcase
      end
      ST_MEM: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.i_or_d  = 1'b1;
        ctrl_s.mem_we  = (op_r == OP_STORE);
      end
      ST_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = (op_r == OP_LOAD);
      end
      ST_HALT: ctrl_s = '0;
      default: ctrl_s = '0;
    endcase
  end

  // Reset forces every control output low without waiting for a clock.
  assign ctrl_out_s = rst_n ? ctrl_s : '0;

  assign mem_req    = ctrl_out_s.mem_req;
  assign mem_we     = ctrl_out_s.mem_we;
  assign i_or_d     = ctrl_out_s.i_or_d;
  assign ir_write   = ctrl_out_s.ir_write;
  assign pc_write   = ctrl_out_s.pc_write;
  assign reg_write  = ctrl_out_s.reg_write;
  assign mem_to_reg = ctrl_out_s.mem_to_reg;
  assign alu_src_a  = ctrl_out_s.alu_src_a;
  assign alu_src_b  = ctrl_out_s.alu_src_b;
  assign alu_op     = ctrl_out_s.alu_op;
  assign pc_src     = ctrl_out_s.pc_src;
  assign fault      = rst_n ? fault_r : 2'b00;
  assign state      = state_r;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum cycles any state SHALL wait for mem_ready before faulting (legal range 1..255).
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state changes occur on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 opcode  in  7  instruction[6:0] from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory completes the current request this cycle.
REQ-008 mem_req  out  1  memory access request, held until mem_ready.
REQ-009 mem_we  out  1  write strobe, valid with mem_req.
REQ-010 i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 ir_write, pc_write, reg_write  out  1 each  single-cycle register enables.
REQ-012 mem_to_reg  out  1  write-back select: 1 = memory data, 0 = ALUOut.
REQ-013 alu_src_a  out  2  00 = PC, 01 = rs1, 10 = old PC.
REQ-014 alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
REQ-015 alu_op  out  2  00 = add, 01 = subtract, 10 = funct-decoded.
REQ-016 pc_src  out  1  0 = ALU result, 1 = ALUOut (branch target).
REQ-017 fault  out  2  sticky: 00 = none, 01 = illegal opcode, 10 = memory timeout.
REQ-018 state  out  3  current state encoding, for debug.

Function
REQ-019 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; outputs not listed for a state SHALL be 0.
REQ-020 FETCH: mem_req=1, i_or_d=0, mem_we=0; stay while !mem_ready; on mem_ready the same cycle asserts ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=01, alu_op=00, pc_src=0, then go to DECODE.
REQ-021 DECODE: alu_src_a=10, alu_src_b=10, alu_op=00 (branch target into ALUOut); latch opcode into an internal register.
REQ-022 DECODE transitions: 0110011, 0010011, 0000011, 0100011, 1100011 -> EXEC; 0000000 -> FETCH (no-op); any other value -> HALT with fault=01.
REQ-023 EXEC R-type (0110011): alu_src_a=01, alu_src_b=00, alu_op=10, then WB.
REQ-024 EXEC I-type (0010011): alu_src_a=01, alu_src_b=10, alu_op=10, then WB.
REQ-025 EXEC lw/sw: alu_src_a=01, alu_src_b=10, alu_op=00, then MEM.
REQ-026 EXEC beq: alu_src_a=01, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero (combinational), then FETCH.
REQ-027 MEM: mem_req=1, i_or_d=1, mem_we=1 for sw only; stay while !mem_ready; on mem_ready go to WB for lw and FETCH for sw.
REQ-028 WB: reg_write=1, mem_to_reg=1 for lw else 0, then FETCH.
REQ-029 Zero-wait latency SHALL be: beq 3 cycles, R-type/I-type/sw 4 cycles, lw 5 cycles, no-op 2 cycles.
REQ-030 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0.
  - If the counter reaches MEM_TIMEOUT, the next state SHALL be HALT with fault=10.
  - mem_ready in the same cycle as the limit SHALL win: the access completes and no fault is raised.
REQ-031 HALT SHALL be absorbing: all enables 0, mem_req=0, fault held until reset.
REQ-032 mem_req SHALL never drop while waiting, and mem_we SHALL be stable throughout a request.

Reset
REQ-033 While rst_n=0: state=FETCH, fault=00, wait counter=0, latched opcode=0, and all outputs except state SHALL be forced to 0 combinationally.
REQ-034 Reset asserted mid-access SHALL abandon the access immediately; after release the FSM starts FETCH with a new request.

Structure
REQ-035 Shared package riscv_ctrl_pkg SHALL hold the opcode constants, state enum, alu_op/alu_src encodings and fault codes.
REQ-036 One sub-module, mem_wait_timer (clear, count, limit reached), SHALL implement the REQ-030 counter.

Verification
REQ-037 Stream add, addi, sw, lw, beq with mem_ready tied to 1 -> state sequences 0-1-2-4, 0-1-2-4, 0-1-2-3, 0-1-2-3-4, 0-1-2; reg_write pulses exactly once for add, addi and lw.
REQ-038 beq with zero=1, then beq with zero=0 -> pc_write=1 with pc_src=1 in EXEC for the first; pc_write=0 in EXEC for the second.
REQ-039 lw with mem_ready low for 5 cycles in MEM (MEM_TIMEOUT=16) -> MEM held 6 cycles with mem_req=1 and i_or_d=1, then WB with mem_to_reg=1.
REQ-040 mem_ready never asserted in FETCH (MEM_TIMEOUT=16) -> HALT after 16 cycles, fault=10, mem_req=0; a second run with mem_ready=1 on cycle 16 -> DECODE with no fault.
REQ-041 opcode 1111111 -> HALT with fault=01; opcode 0000000 -> DECODE returns to FETCH with no enables asserted.
REQ-042 rst_n pulsed low during sw MEM wait -> outputs 0 immediately; after release FETCH is entered, mem_we was never asserted outside MEM, and fault=00.
